key_command_decoder: RTL

//   Turns the raw 32-bit USB keycode word (4 HID slots) into frame-aligned per-player

---
 rtl/key_command_decoder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/key_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : key_command_decoder
// Purpose  : Turns the raw 32-bit USB HID keycode word (four 8-bit slots) into
//            frame-aligned per-player tank commands. It debounces report
//            changes, decodes direction keys, and latches one-shot fire
//            requests so that vsync-rate consumers never miss a press.
// Ports    : clk_i          system clock
//            reset_i        synchronous, active-high reset
//            keycode_i      slots [7:0],[15:8],[23:16],[31:24]; 8'h00 = empty
//            frame_tick_i   one-clock strobe per video frame
//            p1_dir_o       0 none, 1 up, 2 down, 3 left, 4 right
//            p1_move_o      high when p1_dir_o != 0
//            p1_fire_o      high for one frame per accepted shot
//            p2_dir_o / p2_move_o / p2_fire_o   same for player 2
//            any_key_o      accepted word is non-zero
//            key_changes_o  number of accepted-word updates (wraps)
// Revision : 1.0  initial release
// ============================================================================
module key_command_decoder #(
  parameter int unsigned STABLE_CYCLES   = 1000,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter logic [7:0]  P1_UP   = 8'h1A,
  parameter logic [7:0]  P1_DN   = 8'h16,
  parameter logic [7:0]  P1_LT   = 8'h04,
  parameter logic [7:0]  P1_RT   = 8'h07,
  parameter logic [7:0]  P1_FIRE = 8'h2C,
  parameter logic [7:0]  P2_UP   = 8'h52,
  parameter logic [7:0]  P2_DN   = 8'h51,
  parameter logic [7:0]  P2_LT   = 8'h50,
  parameter logic [7:0]  P2_RT   = 8'h4F,
  parameter logic [7:0]  P2_FIRE = 8'h28
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] keycode_i,
  input  logic        frame_tick_i,
  output logic [2:0]  p1_dir_o,
  output logic        p1_move_o,
  output logic        p1_fire_o,
  output logic [2:0]  p2_dir_o,
  output logic        p2_move_o,
  output logic        p2_fire_o,
  output logic        any_key_o,
  output logic [15:0] key_changes_o
);

  localparam int unsigned CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam int unsigned CD_W  = (COOLDOWN_FRAMES == 0) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CD_W-1:0]  C_CD_INIT = CD_W'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_FIRE    = 2'd2,
    S_COOL    = 2'd3
  } fire_state_e;

  // True when any of the four slots carries the given code.
  function automatic logic key_held(input logic [31:0] word, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (word[8*s +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // Walk slots from highest to lowest so the lowest-index match wins.
  function automatic logic [2:0] dir_decode(input logic [31:0] word,
                                            input logic [7:0] up, input logic [7:0] dn,
                                            input logic [7:0] lt, input logic [7:0] rt);
    logic [2:0] d;
    logic [7:0] slot;
    d = 3'd0;
    for (int s = 3; s >= 0; s--) begin
      slot = word[8*s +: 8];
      if      (slot == up) d = 3'd1;
      else if (slot == dn) d = 3'd2;
      else if (slot == lt) d = 3'd3;
      else if (slot == rt) d = 3'd4;
    end
    return d;
  endfunction

  // ---------------------------------------------------------------- filter
  logic [31:0]      kc_q;
  logic [31:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stable_q, stable_d;
  logic [15:0]      key_changes_q, key_changes_d;
  logic             w_stable_upd;

  assign w_stable_upd = (cnt_q == C_CNT_MAX) && (stable_q != cand_q);

  always_comb begin
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    stable_d      = stable_q;
    key_changes_d = key_changes_q;
    if (kc_q != cand_q) begin
      cand_d = kc_q;
      cnt_d  = '0;
    end else if (cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (w_stable_upd) begin
      stable_d      = cand_q;
      key_changes_d = key_changes_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kc_q          <= '0;
      cand_q        <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      key_changes_q <= '0;
    end else begin
      kc_q          <= keycode_i;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      key_changes_q <= key_changes_d;
    end
  end

  // ---------------------------------------------------------------- decode
  logic [2:0] w_p1_dir, w_p2_dir;
  logic [1:0] w_fire_edge;

  assign w_p1_dir = dir_decode(stable_q, P1_UP, P1_DN, P1_LT, P1_RT);
  assign w_p2_dir = dir_decode(stable_q, P2_UP, P2_DN, P2_LT, P2_RT);

  // A press is a fire code appearing in the word being accepted this clock
  // that was absent from the word it replaces.
  assign w_fire_edge[0] = w_stable_upd && key_held(cand_q, P1_FIRE) && !key_held(stable_q, P1_FIRE);
  assign w_fire_edge[1] = w_stable_upd && key_held(cand_q, P2_FIRE) && !key_held(stable_q, P2_FIRE);

  // ------------------------------------------------------- frame publish
  logic [2:0] p1_dir_q, p2_dir_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      p1_dir_q <= 3'd0;
      p2_dir_q <= 3'd0;
    end else if (frame_tick_i) begin
      p1_dir_q <= w_p1_dir;
      p2_dir_q <= w_p2_dir;
    end
  end

  // ------------------------------------------------------ fire FSMs (x2)
  fire_state_e     fst_q [2];
  logic [CD_W-1:0] cd_q  [2];
  logic [1:0]      fire_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int p = 0; p < 2; p++) begin
        fst_q[p] <= S_IDLE;
        cd_q[p]  <= '0;
      end
      fire_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        case (fst_q[p])
          S_IDLE: begin
            // A tick coinciding with the press does not fire; wait for the next.
            if (w_fire_edge[p]) fst_q[p] <= S_PENDING;
          end
          S_PENDING: begin
            if (frame_tick_i) begin
              fire_q[p] <= 1'b1;
              fst_q[p]  <= S_FIRE;
            end
          end
          S_FIRE: begin
            if (frame_tick_i) begin
              fire_q[p] <= 1'b0;
              cd_q[p]   <= C_CD_INIT;
              fst_q[p]  <= (COOLDOWN_FRAMES == 0) ? S_IDLE : S_COOL;
            end
          end
          S_COOL: begin
            if (frame_tick_i) begin
              if (cd_q[p] <= CD_W'(1)) begin
                cd_q[p]  <= '0;
                fst_q[p] <= S_IDLE;
              end else begin
                cd_q[p] <= cd_q[p] - 1'b1;
              end
            end
          end
          default: fst_q[p] <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign p1_dir_o      = p1_dir_q;
  assign p1_move_o     = (p1_dir_q != 3'd0);
  assign p1_fire_o     = fire_q[0];
  assign p2_dir_o      = p2_dir_q;
  assign p2_move_o     = (p2_dir_q != 3'd0);
  assign p2_fire_o     = fire_q[1];
  assign any_key_o     = (stable_q != 32'd0);
  assign key_changes_o = key_changes_q;

endmodule
`default_nettype wire
